// File: rtl/serial_adder_mux_pkg.sv
// ============================================================================
// Module  : serial_add_pkg
// Purpose : Shared types and constants for the bit-serial adder/subtractor.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package serial_add_pkg;

  localparam int MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit-counter width; a 1-bit operand still needs a 1-bit counter
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_adder_mux_if.sv
// ============================================================================
// Module  : serial_adder_mux_if
// Purpose : Operand/result bundle between a requester and the serial adder.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface serial_adder_mux_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, sum, cout, ovf
  );

endinterface

`default_nettype wire

// File: rtl/serial_adder_mux_fa_mux_cell.sv
// ============================================================================
// Module  : fa_mux_cell
// Purpose : 1-bit full adder built from two 8:1 truth-table multiplexers.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module fa_mux_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_carry
);

  // Bit k of each table is the output for {a,b,cin} == k
  localparam logic [7:0] c_sum_tt   = 8'b1001_0110;
  localparam logic [7:0] c_carry_tt = 8'b1110_1000;

  logic [2:0] w_sel;

  always_comb begin
    w_sel   = {i_a, i_b, i_cin};
    o_sum   = c_sum_tt[w_sel];
    o_carry = c_carry_tt[w_sel];
  end

endmodule

`default_nettype wire

// File: rtl/serial_adder_mux.sv
// ============================================================================
// Module  : serial_adder_mux
// Purpose : Bit-serial add/subtract, LSB first, one mux full-adder cell.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_adder_mux
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  serial_adder_mux_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);

  generate
    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
      $error("serial_adder_mux: WIDTH out of range");
    end
  endgenerate

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] w_res_next;
  logic             r_carry;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             w_sbit;
  logic             w_cbit;
  logic             w_accept;
  logic             w_last;
  logic             w_busy;
  logic             w_done;

  fa_mux_cell u_cell (
    .i_a     (r_opa[0]),
    .i_b     (r_opb[0]),
    .i_cin   (r_carry),
    .o_sum   (w_sbit),
    .o_carry (w_cbit)
  );

  assign w_accept   = bus.start && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_last     = (r_state == ST_RUN) && (r_cnt == CW'(WIDTH - 1));
  assign w_res_next = (r_res >> 1) | (WIDTH'(w_sbit) << (WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (bus.start) w_next = ST_RUN;
      ST_RUN:  if (w_last)    w_next = ST_DONE;
      ST_DONE: w_next = bus.start ? ST_RUN : ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state == ST_RUN);
    w_done = (r_state == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      // Subtraction is a + ~b + 1, so cin is replaced by the forced 1
      r_opa   <= bus.a;
      r_opb   <= bus.sub ? ~bus.b : bus.b;
      r_carry <= bus.sub | bus.cin;
      r_cnt   <= '0;
      r_res   <= '0;
    end else if (r_state == ST_RUN) begin
      r_opa   <= r_opa >> 1;
      r_opb   <= r_opb >> 1;
      r_carry <= w_cbit;
      r_res   <= w_res_next;
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        // On the MSB step r_carry is the carry into the MSB
        r_sum  <= w_res_next;
        r_cout <= w_cbit;
        r_ovf  <= r_carry ^ w_cbit;
      end
    end
  end

  assign bus.busy = w_busy;
  assign bus.done = w_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
  assign bus.ovf  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder_mux.sv
// ============================================================================
// Module  : tb_serial_adder_mux
// Purpose : Scoreboard bench for serial_adder_mux at WIDTH 8, 1 and 16.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_adder_mux;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_adder_mux_if #(.WIDTH(8))  if8  ();
  serial_adder_mux_if #(.WIDTH(1))  if1  ();
  serial_adder_mux_if #(.WIDTH(16)) if16 ();

  serial_adder_mux #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(if8));
  serial_adder_mux #(.WIDTH(1))  dut1  (.clk(clk), .rst(rst), .bus(if1));
  serial_adder_mux #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));

  int   n_pass  = 0;
  int   n_total = 0;
  int   dc8 = 0, dc1 = 0, dc16 = 0;
  res_t q8[$], q1[$], q16[$];
  res_t e8, e1, e16;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference: two's-complement add of a, b (or ~b) and carry, mod 2^w
  function automatic res_t model(input int w, input logic s, input logic [31:0] a,
                                 input logic [31:0] b, input logic c);
    logic [32:0] mask, t;
    logic [31:0] aa, bb;
    res_t r;
    mask   = (33'd1 << w) - 33'd1;
    aa     = a & mask[31:0];
    bb     = s ? (~b & mask[31:0]) : (b & mask[31:0]);
    t      = {1'b0, aa} + {1'b0, bb} + (s ? 33'd1 : {32'd0, c});
    r.sum  = t[31:0] & mask[31:0];
    r.cout = t[w];
    r.ovf  = (aa[w-1] == bb[w-1]) && (r.sum[w-1] != aa[w-1]);
    return r;
  endfunction

  always @(negedge clk) begin
    if (if8.done === 1'b1) begin
      dc8++;
      if (q8.size() == 0) chk("w8_unexpected_done", 32'd1, 32'd0);
      else begin
        e8 = q8.pop_front();
        chk("w8_sum", {24'd0, if8.sum}, e8.sum);
        chk("w8_cout", {31'd0, if8.cout}, {31'd0, e8.cout});
        chk("w8_ovf", {31'd0, if8.ovf}, {31'd0, e8.ovf});
      end
    end
    if (if1.done === 1'b1) begin
      dc1++;
      if (q1.size() == 0) chk("w1_unexpected_done", 32'd1, 32'd0);
      else begin
        e1 = q1.pop_front();
        chk("w1_sum", {31'd0, if1.sum}, e1.sum);
        chk("w1_cout", {31'd0, if1.cout}, {31'd0, e1.cout});
        chk("w1_ovf", {31'd0, if1.ovf}, {31'd0, e1.ovf});
      end
    end
    if (if16.done === 1'b1) begin
      dc16++;
      if (q16.size() == 0) chk("w16_unexpected_done", 32'd1, 32'd0);
      else begin
        e16 = q16.pop_front();
        chk("w16_sum", {16'd0, if16.sum}, e16.sum);
        chk("w16_cout", {31'd0, if16.cout}, {31'd0, e16.cout});
        chk("w16_ovf", {31'd0, if16.ovf}, {31'd0, e16.ovf});
      end
    end
  end

  function automatic logic dn(input int d);
    case (d)
      8:       return if8.done;
      1:       return if1.done;
      default: return if16.done;
    endcase
  endfunction

  function automatic logic bz(input int d);
    case (d)
      8:       return if8.busy;
      1:       return if1.busy;
      default: return if16.busy;
    endcase
  endfunction

  // Called at a negedge; drives one start cycle and queues the expected result
  task automatic go(input int d, input logic s, input logic [31:0] a,
                    input logic [31:0] b, input logic c);
    case (d)
      8: begin
        if8.start = 1'b1; if8.sub = s; if8.a = a[7:0]; if8.b = b[7:0]; if8.cin = c;
        q8.push_back(model(8, s, a, b, c));
      end
      1: begin
        if1.start = 1'b1; if1.sub = s; if1.a = a[0]; if1.b = b[0]; if1.cin = c;
        q1.push_back(model(1, s, a, b, c));
      end
      default: begin
        if16.start = 1'b1; if16.sub = s; if16.a = a[15:0]; if16.b = b[15:0]; if16.cin = c;
        q16.push_back(model(16, s, a, b, c));
      end
    endcase
    @(negedge clk);
    if8.start = 1'b0; if1.start = 1'b0; if16.start = 1'b0;
  endtask

  // Returns negedges since start was driven, and busy samples seen on the way
  task automatic waitd(input int d, output int lat, output int nb);
    lat = 1;
    nb  = 0;
    while (dn(d) !== 1'b1 && lat < 60) begin
      if (bz(d) === 1'b1) nb++;
      @(negedge clk);
      lat++;
    end
    if (dn(d) !== 1'b1) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run(input int d, input logic s, input logic [31:0] a,
                     input logic [31:0] b, input logic c);
    int lat, nb;
    go(d, s, a, b, c);
    waitd(d, lat, nb);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nb, dcs;
    if8.start = 0;  if8.sub = 0;  if8.a = '0;  if8.b = '0;  if8.cin = 0;
    if1.start = 0;  if1.sub = 0;  if1.a = '0;  if1.b = '0;  if1.cin = 0;
    if16.start = 0; if16.sub = 0; if16.a = '0; if16.b = '0; if16.cin = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy8", {31'd0, if8.busy}, 32'd0);
    chk("rst_done8", {31'd0, if8.done}, 32'd0);
    chk("rst_sum8", {24'd0, if8.sum}, 32'd0);
    chk("rst_cout8", {31'd0, if8.cout}, 32'd0);
    chk("rst_ovf8", {31'd0, if8.ovf}, 32'd0);
    chk("rst_sum16", {16'd0, if16.sum}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: latency and busy length
    go(8, 0, 32'h5A, 32'h33, 0);
    waitd(8, lat, nb);
    chk("t1_latency", lat, 32'd9);
    chk("t1_busy_cycles", nb, 32'd8);
    chk("t1_busy_in_done", {31'd0, if8.busy}, 32'd0);
    @(negedge clk);
    chk("t1_done_one_cycle", {31'd0, if8.done}, 32'd0);
    chk("t1_sum_hold", {24'd0, if8.sum}, 32'h8D);

    // 2: wrap-around and add overflow
    run(8, 0, 32'hFF, 32'h01, 0);
    run(8, 0, 32'h7F, 32'h00, 1);

    // 3: subtraction, cin must not matter
    run(8, 1, 32'h10, 32'h20, 0);
    run(8, 1, 32'h10, 32'h20, 1);
    run(8, 1, 32'h80, 32'h01, 0);
    run(8, 1, 32'h80, 32'h01, 1);

    // 4a: start mid-RUN is ignored
    dcs = dc8;
    go(8, 0, 32'h12, 32'h34, 0);
    repeat (2) @(negedge clk);
    if8.start = 1'b1; if8.sub = 1'b1; if8.a = 8'hFF; if8.b = 8'hEE;
    @(negedge clk);
    if8.start = 1'b0;
    waitd(8, lat, nb);
    repeat (12) @(negedge clk);
    chk("t4_single_done", dc8 - dcs, 32'd1);

    // 4b: back-to-back start from DONE
    go(8, 0, 32'hA0, 32'h0B, 1);
    waitd(8, lat, nb);
    go(8, 1, 32'h03, 32'h05, 0);
    chk("t4_b2b_busy", {31'd0, if8.busy}, 32'd1);
    chk("t4_b2b_sum_hold", {24'd0, if8.sum}, 32'hAC);
    waitd(8, lat, nb);
    chk("t4_b2b_latency", lat, 32'd9);
    @(negedge clk);

    // 5: reset aborts a run
    go(8, 0, 32'h11, 32'h22, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    q8.delete();
    dcs = dc8;
    chk("t5_busy", {31'd0, if8.busy}, 32'd0);
    chk("t5_done", {31'd0, if8.done}, 32'd0);
    chk("t5_sum", {24'd0, if8.sum}, 32'd0);
    chk("t5_cout_ovf", {30'd0, if8.cout, if8.ovf}, 32'd0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("t5_no_done", dc8 - dcs, 32'd0);
    run(8, 0, 32'hC8, 32'h64, 1);

    // 6: WIDTH=1 truth table
    for (int i = 0; i < 8; i++) begin
      go(1, 0, {31'd0, i[2]}, {31'd0, i[1]}, i[0]);
      waitd(1, lat, nb);
      chk("w1_latency", lat, 32'd2);
      @(negedge clk);
    end
    chk("w1_done_count", dc1, 32'd8);

    // 6b: WIDTH=16 random regression
    for (int i = 0; i < 16; i++) begin
      run(16, 1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)));
    end
    run(16, 0, 32'hFFFF, 32'hFFFF, 1);
    run(16, 1, 32'h0000, 32'h0001, 0);
    chk("w16_done_count", dc16, 32'd18);
    chk("queues_drained", q8.size() + q1.size() + q16.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
